wb_client_arbiter: RTL and testbench

WB_CLIENT_ARBITER -- requirements
Module: wb_client_arbiter

---
 rtl/wb_arb_pkg.sv | 39 +++
 rtl/arb_priority_pick.sv | 32 +++
 rtl/wb_client_arbiter.sv | 170 +++++++++++++++++
 tb/tb_wb_client_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types for the Wishbone-style client arbiter: client ids, FSM states,
// VGA scan-state encodings and the latched transaction record.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        CPU  = 2'd0,
        VGA  = 2'd1,
        UART = 2'd2,
        NONE = 2'd3
    } client_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    // VGA scan states: 0 = inactive, 1 = about to be active, 2 = active.
    // Encoding 3 is unused and treated like inactive.
    localparam logic [1:0] VGA_INACTIVE   = 2'd0;
    localparam logic [1:0] VGA_PRE_ACTIVE = 2'd1;
    localparam logic [1:0] VGA_ACTIVE     = 2'd2;

    // True while the display needs the SRAM exclusively.
    function automatic logic vga_owns_bus(input logic [1:0] vga_state);
        return (vga_state == VGA_PRE_ACTIVE) || (vga_state == VGA_ACTIVE);
    endfunction

    // Everything captured at grant time and replayed onto the SRAM bus.
    typedef struct packed {
        client_t     client;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
    } txn_t;

endpackage

// File: rtl/arb_priority_pick.sv
// Combinational winner selection: VGA owns the bus during its active window,
// otherwise CPU/UART share it round-robin and VGA takes leftover slots.
module arb_priority_pick
    import wb_arb_pkg::*;
(
    input  logic       cpu_req,
    input  logic       vga_req,
    input  logic       uart_req,
    input  logic [1:0] vga_state,
    input  client_t    rr_last,
    output client_t    winner
);

    // Pick at most one requesting client; NONE when nobody is eligible.
    always_comb begin
        winner = NONE;
        if (vga_owns_bus(vga_state)) begin
            if (vga_req) begin
                winner = VGA;
            end
        end else if (cpu_req && uart_req) begin
            winner = (rr_last == CPU) ? UART : CPU;
        end else if (cpu_req) begin
            winner = CPU;
        end else if (uart_req) begin
            winner = UART;
        end else if (vga_req) begin
            winner = VGA;
        end
    end

endmodule

// File: rtl/wb_client_arbiter.sv
// Three-client SRAM arbiter (CPU, VGA, UART). One transaction at a time:
// IDLE -> ISSUE (1-cycle strobe) -> WAIT (until SRAM ready or timeout) -> DONE (ack).
// Bus outputs come from the latched transaction and the state register only,
// so no request input reaches the SRAM side combinationally.
module wb_client_arbiter
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        nrst,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_sel,
    output logic        cpu_ack,

    input  logic        vga_req,
    input  logic [31:0] vga_addr,
    input  logic [3:0]  vga_sel,
    input  logic [1:0]  vga_state,
    output logic        vga_ack,

    input  logic        uart_req,
    input  logic        uart_we,
    input  logic [31:0] uart_addr,
    input  logic [31:0] uart_wdata,
    input  logic [3:0]  uart_sel,
    output logic        uart_ack,

    input  logic        sram_busy,
    input  logic [31:0] sram_rdata,
    output logic        bus_read,
    output logic        bus_write,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,

    output logic [1:0]  current_client,
    output logic [31:0] rdata,
    output logic        bus_err
);

    // Counter value on the last busy WAIT cycle before giving up.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    arb_state_t  state_reg;
    arb_state_t  state_next;
    client_t     rr_last_reg;
    client_t     winner;
    txn_t        txn_reg;
    txn_t        txn_pick;
    logic [7:0]  wait_cnt_reg;
    logic [31:0] rdata_reg;
    logic        bus_err_reg;
    logic        grant;
    logic        timeout_hit;

    arb_priority_pick u_pick (
        .cpu_req   (cpu_req),
        .vga_req   (vga_req),
        .uart_req  (uart_req),
        .vga_state (vga_state),
        .rr_last   (rr_last_reg),
        .winner    (winner)
    );

    // Start only when someone eligible asks and the SRAM is ready.
    assign grant       = (state_reg == IDLE) && (winner != NONE) && !sram_busy;
    assign timeout_hit = (state_reg == WAIT) && sram_busy && (wait_cnt_reg == TIMEOUT_LAST);

    // Route the winning client's request fields into a transaction record.
    always_comb begin
        txn_pick        = '0;
        txn_pick.client = winner;
        case (winner)
            CPU: begin
                txn_pick.we    = cpu_we;
                txn_pick.addr  = cpu_addr;
                txn_pick.wdata = cpu_wdata;
                txn_pick.sel   = cpu_sel;
            end
            VGA: begin
                txn_pick.we    = 1'b0;
                txn_pick.addr  = vga_addr;
                txn_pick.sel   = vga_sel;
            end
            UART: begin
                txn_pick.we    = uart_we;
                txn_pick.addr  = uart_addr;
                txn_pick.wdata = uart_wdata;
                txn_pick.sel   = uart_sel;
            end
            default: txn_pick.client = NONE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; a dropped request never aborts an accepted transaction.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT: begin
                if (!sram_busy) begin
                    state_next = DONE;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Transaction latch, round-robin memory, wait counter, read data and error pulse.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            txn_reg      <= '0;
            rr_last_reg  <= UART;
            wait_cnt_reg <= 8'd0;
            rdata_reg    <= 32'd0;
            bus_err_reg  <= 1'b0;
        end else begin
            if (grant) begin
                txn_reg <= txn_pick;
                if (winner != VGA) begin
                    rr_last_reg <= winner;
                end
            end
            if (state_reg == ISSUE) begin
                wait_cnt_reg <= 8'd0;
            end else if ((state_reg == WAIT) && sram_busy) begin
                wait_cnt_reg <= wait_cnt_reg + 8'd1;
            end
            if ((state_reg == WAIT) && !sram_busy && !txn_reg.we) begin
                rdata_reg <= sram_rdata;
            end
            bus_err_reg <= timeout_hit;
        end
    end

    // Outputs decoded from the state register and latched transaction.
    always_comb begin
        bus_read       = (state_reg == ISSUE) && !txn_reg.we;
        bus_write      = (state_reg == ISSUE) &&  txn_reg.we;
        cpu_ack        = (state_reg == DONE)  && (txn_reg.client == CPU);
        vga_ack        = (state_reg == DONE)  && (txn_reg.client == VGA);
        uart_ack       = (state_reg == DONE)  && (txn_reg.client == UART);
        current_client = (state_reg == IDLE) ? NONE : txn_reg.client;
    end

    assign bus_addr  = txn_reg.addr;
    assign bus_wdata = txn_reg.wdata;
    assign bus_sel   = txn_reg.sel;
    assign rdata     = rdata_reg;
    assign bus_err   = bus_err_reg;

endmodule

// File: tb/tb_wb_client_arbiter.sv
// Directed bench for wb_client_arbiter. A second instance with TIMEOUT = 4
// shares the inputs and is only observed in the timeout scenario.
module tb_wb_client_arbiter;

    logic        clk = 1'b0;
    logic        nrst = 1'b1;
    logic        cpu_req = 0, cpu_we = 0;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0;
    logic [3:0]  cpu_sel = 0;
    logic        vga_req = 0;
    logic [31:0] vga_addr = 0;
    logic [3:0]  vga_sel = 0;
    logic [1:0]  vga_state = 0;
    logic        uart_req = 0, uart_we = 0;
    logic [31:0] uart_addr = 0, uart_wdata = 0;
    logic [3:0]  uart_sel = 0;
    logic        sram_busy = 0;
    logic [31:0] sram_rdata = 0;

    logic        cpu_ack, vga_ack, uart_ack, bus_read, bus_write, bus_err;
    logic [31:0] bus_addr, bus_wdata, rdata;
    logic [3:0]  bus_sel;
    logic [1:0]  current_client;

    logic        t_cpu_ack, t_vga_ack, t_uart_ack, t_bus_read, t_bus_write, t_bus_err;
    logic [31:0] t_bus_addr, t_bus_wdata, t_rdata;
    logic [3:0]  t_bus_sel;
    logic [1:0]  t_current_client;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_client_arbiter dut (
        .clk(clk), .nrst(nrst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_sel(cpu_sel), .cpu_ack(cpu_ack),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_sel(vga_sel), .vga_state(vga_state),
        .vga_ack(vga_ack),
        .uart_req(uart_req), .uart_we(uart_we), .uart_addr(uart_addr), .uart_wdata(uart_wdata),
        .uart_sel(uart_sel), .uart_ack(uart_ack),
        .sram_busy(sram_busy), .sram_rdata(sram_rdata), .bus_read(bus_read),
        .bus_write(bus_write), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_sel(bus_sel),
        .current_client(current_client), .rdata(rdata), .bus_err(bus_err)
    );

    wb_client_arbiter #(.TIMEOUT(4)) dut_to (
        .clk(clk), .nrst(nrst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_sel(cpu_sel), .cpu_ack(t_cpu_ack),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_sel(vga_sel), .vga_state(vga_state),
        .vga_ack(t_vga_ack),
        .uart_req(uart_req), .uart_we(uart_we), .uart_addr(uart_addr), .uart_wdata(uart_wdata),
        .uart_sel(uart_sel), .uart_ack(t_uart_ack),
        .sram_busy(sram_busy), .sram_rdata(sram_rdata), .bus_read(t_bus_read),
        .bus_write(t_bus_write), .bus_addr(t_bus_addr), .bus_wdata(t_bus_wdata), .bus_sel(t_bus_sel),
        .current_client(t_current_client), .rdata(t_rdata), .bus_err(t_bus_err)
    );

    // Advance to just after the next rising edge: sample, then drive.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_sel = 0;
        vga_req = 0; vga_addr = 0; vga_sel = 0; vga_state = 0;
        uart_req = 0; uart_we = 0; uart_addr = 0; uart_wdata = 0; uart_sel = 0;
        sram_busy = 0; sram_rdata = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        tick();
        nrst = 0;
        tick();
        tick();
        nrst = 1;
    endtask

    task automatic test_reset();
        #2;
        nrst = 0;
        #1;
        n_checks++;
        if (current_client !== 2'd3) begin
            n_fail++; $display("FAIL reset_client: got %0d expected 3", current_client);
        end
        n_checks++;
        if ({bus_read, bus_write, cpu_ack, vga_ack, uart_ack, bus_err} !== 6'b0) begin
            n_fail++; $display("FAIL reset_strobes: got %b expected 000000",
                {bus_read, bus_write, cpu_ack, vga_ack, uart_ack, bus_err});
        end
        n_checks++;
        if ({bus_addr, bus_wdata, bus_sel, rdata} !== 100'd0) begin
            n_fail++; $display("FAIL reset_data: got addr %h wdata %h sel %h rdata %h expected zeros",
                bus_addr, bus_wdata, bus_sel, rdata);
        end
        tick();
        tick();
        nrst = 1;
        $display("reset: client=%0d rdata=%h", current_client, rdata);
    endtask

    task automatic test_cpu_read();
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; cpu_sel = 4'hF;
        sram_rdata = 32'hA5A5_0001;
        tick(); // cycle 1: ISSUE
        n_checks++;
        if ({bus_read, bus_write} !== 2'b10) begin
            n_fail++; $display("FAIL cpu_read_issue: got read/write %b expected 10", {bus_read, bus_write});
        end
        n_checks++;
        if (bus_addr !== 32'h10 || bus_sel !== 4'hF || current_client !== 2'd0) begin
            n_fail++; $display("FAIL cpu_read_latch: got addr %h sel %h client %0d expected 10 f 0",
                bus_addr, bus_sel, current_client);
        end
        cpu_req = 0;  // dropping the request must not abort
        tick(); // cycle 2: WAIT
        n_checks++;
        if ({bus_read, cpu_ack} !== 2'b00 || current_client !== 2'd0) begin
            n_fail++; $display("FAIL cpu_read_wait: got read %b ack %b client %0d expected 0 0 0",
                bus_read, cpu_ack, current_client);
        end
        tick(); // cycle 3: DONE
        n_checks++;
        if (cpu_ack !== 1'b1 || {vga_ack, uart_ack} !== 2'b00) begin
            n_fail++; $display("FAIL cpu_read_ack: got cpu %b vga %b uart %b expected 1 0 0",
                cpu_ack, vga_ack, uart_ack);
        end
        n_checks++;
        if (rdata !== 32'hA5A5_0001) begin
            n_fail++; $display("FAIL cpu_read_rdata: got %h expected a5a50001", rdata);
        end
        tick(); // cycle 4: IDLE
        n_checks++;
        if (cpu_ack !== 1'b0 || current_client !== 2'd3) begin
            n_fail++; $display("FAIL cpu_read_idle: got ack %b client %0d expected 0 3", cpu_ack, current_client);
        end
        $display("cpu_read: addr=10 rdata=%h", rdata);
    endtask

    task automatic test_round_robin();
        int got[4];
        int exp_seq[4];
        int ng;
        exp_seq = '{0, 2, 0, 2};
        ng = 0;
        do_reset();
        cpu_req = 1; uart_req = 1; cpu_addr = 32'h100; uart_addr = 32'h200;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            tick();
            if (bus_read === 1'b1) begin
                got[ng] = int'(current_client);
                $display("round_robin: grant %0d client=%0d addr=%h", ng, current_client, bus_addr);
                ng++;
            end
        end
        n_checks++;
        if (ng != 4) begin
            n_fail++; $display("FAIL rr_grant_count: got %0d expected 4", ng);
        end
        for (int i = 0; i < ng; i++) begin
            n_checks++;
            if (got[i] != exp_seq[i]) begin
                n_fail++; $display("FAIL rr_order[%0d]: got %0d expected %0d", i, got[i], exp_seq[i]);
            end
        end
        clear_inputs();
    endtask

    task automatic test_vga_priority();
        int got[4];
        logic [31:0] got_addr[4];
        int exp_seq[4];
        int ng;
        exp_seq = '{1, 1, 1, 0};
        ng = 0;
        do_reset();
        vga_state = 2;
        cpu_req = 1; vga_req = 1; uart_req = 1;
        cpu_addr = 32'h100; vga_addr = 32'h300; uart_addr = 32'h200;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            tick();
            if (bus_read === 1'b1 || bus_write === 1'b1) begin
                got[ng] = int'(current_client);
                got_addr[ng] = bus_addr;
                $display("vga_priority: grant %0d client=%0d addr=%h", ng, current_client, bus_addr);
                ng++;
                if (ng == 3) vga_state = 0;
            end
        end
        n_checks++;
        if (ng != 4) begin
            n_fail++; $display("FAIL vga_grant_count: got %0d expected 4", ng);
        end
        for (int i = 0; i < ng; i++) begin
            n_checks++;
            if (got[i] != exp_seq[i]) begin
                n_fail++; $display("FAIL vga_order[%0d]: got %0d expected %0d", i, got[i], exp_seq[i]);
            end
            n_checks++;
            if (got_addr[i] !== ((exp_seq[i] == 1) ? 32'h300 : 32'h100)) begin
                n_fail++; $display("FAIL vga_addr[%0d]: got %h expected %h", i, got_addr[i],
                    (exp_seq[i] == 1) ? 32'h300 : 32'h100);
            end
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        int first_rd, second_rd, ack_cyc;
        first_rd = -1; second_rd = -1; ack_cyc = -1;
        do_reset();
        cpu_req = 1; cpu_addr = 32'h20; sram_rdata = 32'h0BAD_F00D;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (bus_read === 1'b1) begin
                if (first_rd < 0) first_rd = c;
                else if (second_rd < 0) second_rd = c;
            end
            if (cpu_ack === 1'b1 && ack_cyc < 0) ack_cyc = c;
        end
        $display("back_to_back: first=%0d ack=%0d second=%0d", first_rd, ack_cyc, second_rd);
        n_checks++;
        if (first_rd != 1 || ack_cyc != 3) begin
            n_fail++; $display("FAIL b2b_latency: got issue %0d ack %0d expected 1 3", first_rd, ack_cyc);
        end
        n_checks++;
        if (second_rd != 5) begin
            n_fail++; $display("FAIL b2b_regrant: got cycle %0d expected 5", second_rd);
        end
        clear_inputs();
    endtask

    task automatic test_uart_write();
        do_reset();
        uart_req = 1; uart_we = 1; uart_addr = 32'h40; uart_wdata = 32'hDEAD_BEEF; uart_sel = 4'hF;
        sram_rdata = 32'h7777_7777;
        tick(); // cycle 1: ISSUE
        n_checks++;
        if ({bus_read, bus_write} !== 2'b01 || current_client !== 2'd2) begin
            n_fail++; $display("FAIL uart_issue: got read/write %b client %0d expected 01 2",
                {bus_read, bus_write}, current_client);
        end
        n_checks++;
        if (bus_wdata !== 32'hDEAD_BEEF || bus_sel !== 4'hF || bus_addr !== 32'h40) begin
            n_fail++; $display("FAIL uart_latch: got wdata %h sel %h addr %h expected deadbeef f 40",
                bus_wdata, bus_sel, bus_addr);
        end
        sram_busy = 1; uart_req = 0;
        for (int c = 2; c <= 6; c++) begin
            tick();
            if (c == 6) sram_busy = 0;
            n_checks++;
            if (bus_write !== 1'b0 || uart_ack !== 1'b0 || current_client !== 2'd2) begin
                n_fail++; $display("FAIL uart_wait_c%0d: got write %b ack %b client %0d expected 0 0 2",
                    c, bus_write, uart_ack, current_client);
            end
        end
        tick(); // cycle 7: DONE
        n_checks++;
        if (uart_ack !== 1'b1 || cpu_ack !== 1'b0) begin
            n_fail++; $display("FAIL uart_ack_c7: got uart %b cpu %b expected 1 0", uart_ack, cpu_ack);
        end
        n_checks++;
        if (rdata !== 32'd0) begin
            n_fail++; $display("FAIL uart_no_capture: got %h expected 0", rdata);
        end
        $display("uart_write: wdata=%h ack=%b", bus_wdata, uart_ack);
        tick();
        clear_inputs();
    endtask

    task automatic test_timeout();
        logic saw_ack;
        saw_ack = 0;
        do_reset();
        cpu_req = 1; cpu_addr = 32'h50;
        tick(); // cycle 1: ISSUE
        sram_busy = 1; cpu_req = 0;
        for (int c = 2; c <= 5; c++) begin
            tick();
            if (t_cpu_ack === 1'b1) saw_ack = 1;
            n_checks++;
            if (t_current_client !== 2'd0 || t_bus_err !== 1'b0) begin
                n_fail++; $display("FAIL timeout_wait_c%0d: got client %0d err %b expected 0 0",
                    c, t_current_client, t_bus_err);
            end
        end
        tick(); // cycle 6: back in IDLE with error pulse
        n_checks++;
        if (t_bus_err !== 1'b1 || t_current_client !== 2'd3) begin
            n_fail++; $display("FAIL timeout_err: got err %b client %0d expected 1 3", t_bus_err, t_current_client);
        end
        for (int c = 7; c <= 9; c++) begin
            tick();
            if (t_cpu_ack === 1'b1) saw_ack = 1;
        end
        n_checks++;
        if (t_bus_err !== 1'b0) begin
            n_fail++; $display("FAIL timeout_err_pulse: got %b expected 0", t_bus_err);
        end
        n_checks++;
        if (saw_ack !== 1'b0) begin
            n_fail++; $display("FAIL timeout_no_ack: got %b expected 0", saw_ack);
        end
        $display("timeout: bus_err pulsed, client=%0d", t_current_client);
        do_reset();
    endtask

    task automatic test_reset_mid_wait();
        logic saw_activity;
        saw_activity = 0;
        do_reset();
        cpu_req = 1; cpu_addr = 32'h60; cpu_sel = 4'h3; sram_rdata = 32'h1234_5678;
        tick(); cpu_req = 0;
        tick(); tick(); tick(); // transaction done, rdata loaded
        cpu_req = 1; cpu_addr = 32'h44; cpu_sel = 4'hC;
        tick(); // ISSUE
        sram_busy = 1; cpu_req = 0;
        tick(); // WAIT
        #2;
        nrst = 0;
        #1;
        n_checks++;
        if (current_client !== 2'd3 || {bus_read, bus_write, cpu_ack, bus_err} !== 4'b0) begin
            n_fail++; $display("FAIL midreset_ctrl: got client %0d strobes %b expected 3 0000",
                current_client, {bus_read, bus_write, cpu_ack, bus_err});
        end
        n_checks++;
        if (rdata !== 32'd0 || bus_addr !== 32'd0 || bus_sel !== 4'd0 || bus_wdata !== 32'd0) begin
            n_fail++; $display("FAIL midreset_data: got rdata %h addr %h sel %h wdata %h expected zeros",
                rdata, bus_addr, bus_sel, bus_wdata);
        end
        tick();
        nrst = 1; sram_busy = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (cpu_ack === 1'b1 || bus_read === 1'b1) saw_activity = 1;
        end
        n_checks++;
        if (saw_activity !== 1'b0) begin
            n_fail++; $display("FAIL midreset_no_ack: got %b expected 0", saw_activity);
        end
        $display("reset_mid_wait: client=%0d rdata=%h", current_client, rdata);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_cpu_read();
        test_round_robin();
        test_vga_priority();
        test_back_to_back();
        test_uart_write();
        test_timeout();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
